// File: rtl/split_view_renderer.sv
// Split-screen top-down racing renderer.
// Turns a raster scan position into map and car-sprite ROM addresses,
// then merges the returned texels into one {R,G,B} pixel, with a fixed
// latency of two pixel ticks for colour and syncs alike.
// Optional feature macro: SPLIT_VIEW_GHOST_EN (draws the enemy car in each view).
module split_view_renderer #(
  parameter int          NUM_VIEWS       = 2,
  parameter int          SCALE_SHIFT     = 1,
  parameter int          MAP_WIDTH       = 320,
  parameter int          MAP_HEIGHT      = 240,
  parameter int          SPRITE_SIZE     = 75,
  parameter logic [11:0] TRANSPARENT     = 12'h000,
  parameter logic [11:0] OUT_BOUND_COLOR = 12'h6B4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  p0_x,
  input  logic [9:0]  p0_y,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [3:0]  p0_deg,
  input  logic [3:0]  p1_deg,
  output logic [16:0] map_addr,
  input  logic [11:0] map_rgb,
  output logic [16:0] car_addr_a,
  output logic [16:0] car_addr_b,
  input  logic [11:0] car_rgb_a,
  input  logic [11:0] car_rgb_b,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_latched
);

  localparam int                 VIEW_W    = (NUM_VIEWS == 2) ? 320 : 640;
  localparam logic signed [11:0] VIEW_CX   = 12'(VIEW_W / 2);
  localparam logic signed [11:0] VIEW_CY   = 12'sd240;
  localparam logic signed [11:0] MAP_OFF_X = 12'(VIEW_W >> (SCALE_SHIFT + 1));
  localparam logic signed [11:0] MAP_OFF_Y = 12'(480 >> (SCALE_SHIFT + 1));
  localparam logic signed [11:0] MAP_W_S   = 12'(MAP_WIDTH);
  localparam logic signed [11:0] MAP_H_S   = 12'(MAP_HEIGHT);
  localparam logic signed [11:0] HALF      = 12'(SPRITE_SIZE >> 1);
  localparam logic [16:0]        SPR_EDGE  = 17'(SPRITE_SIZE);
  localparam logic [16:0]        SPR_AREA  = 17'(SPRITE_SIZE * SPRITE_SIZE);
  localparam logic [16:0]        MAP_W_U   = 17'(MAP_WIDTH);

  // True when an offset from a sprite centre lies inside the sprite square.
  function automatic logic in_box(input logic signed [11:0] dx,
                                  input logic signed [11:0] dy);
    return (dx >= -HALF) && (dx <= HALF) && (dy >= -HALF) && (dy <= HALF);
  endfunction

  // Sprite ROM address: heading selects the frame, offset from top-left selects the texel.
  function automatic logic [16:0] sprite_addr(input logic [3:0]         deg,
                                              input logic signed [11:0] dx,
                                              input logic signed [11:0] dy);
    logic signed [11:0] px;
    logic signed [11:0] py;
    px = dx + HALF;
    py = dy + HALF;
    return 17'(deg) * SPR_AREA + 17'($unsigned(py)) * SPR_EDGE + 17'($unsigned(px));
  endfunction

  // Frame snapshot of both players
  logic [9:0] s0_x, s0_y, s1_x, s1_y;
  logic [3:0] s0_deg, s1_deg;
  logic       vs_prev;

  // Combinational stage-1 terms
  logic               view_r;
  logic [9:0]         me_x, me_y;
  logic [3:0]         me_deg;
  logic signed [11:0] rel_x, row, mx, my;
  logic signed [11:0] self_dx, self_dy;
  logic               off_map, self_hit, sep;
  logic [16:0]        map_lin, self_addr;

  // Pipeline flags and data
  logic        vld_p1, sep_p1, self_p1, off_p1, hs_p1, vs_p1;
  logic        vld_p2, sep_p2, self_p2, off_p2, hs_p2, vs_p2;
  logic [11:0] map_p2, car_a_p2;
  logic [11:0] rgb_next;

`ifdef SPLIT_VIEW_GHOST_EN
  logic [9:0]         en_x, en_y;
  logic [3:0]         en_deg;
  logic signed [11:0] en_cx, en_cy, en_dx, en_dy;
  logic               en_hit;
  logic [16:0]        en_addr;
  logic               en_p1, en_p2;
  logic [11:0]        car_b_p2;
`else
  logic               unused_car_rgb_b;
`endif

  // Latch positions and headings on the vsync_in falling edge; one-clk pulse marks it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_x          <= '0;
      s0_y          <= '0;
      s1_x          <= '0;
      s1_y          <= '0;
      s0_deg        <= '0;
      s1_deg        <= '0;
      vs_prev       <= 1'b0;
      frame_latched <= 1'b0;
    end else begin
      frame_latched <= 1'b0;
      if (pix_en) begin
        vs_prev <= vsync_in;
        if (vs_prev && !vsync_in) begin
          s0_x          <= p0_x;
          s0_y          <= p0_y;
          s1_x          <= p1_x;
          s1_y          <= p1_y;
          s0_deg        <= p0_deg;
          s1_deg        <= p1_deg;
          frame_latched <= 1'b1;
        end
      end
    end
  end

  // View select: right half of a split screen follows player 1
  assign view_r = (NUM_VIEWS == 2) && (h_cnt >= 10'd320);
  assign me_x   = view_r ? s1_x : s0_x;
  assign me_y   = view_r ? s1_y : s0_y;
  assign me_deg = view_r ? s1_deg : s0_deg;
  assign rel_x  = $signed({2'b00, h_cnt}) - (view_r ? 12'sd320 : 12'sd0);
  assign row    = $signed({2'b00, v_cnt});
  assign sep    = (NUM_VIEWS == 2) && ((h_cnt == 10'd319) || (h_cnt == 10'd320));

  // Map lookup, camera centred on the viewing player
  assign mx      = (rel_x >>> SCALE_SHIFT) + $signed({2'b00, me_x}) - MAP_OFF_X;
  assign my      = (row >>> SCALE_SHIFT) + $signed({2'b00, me_y}) - MAP_OFF_Y;
  assign off_map = (mx < 12'sd0) || (my < 12'sd0) || (mx >= MAP_W_S) || (my >= MAP_H_S);
  assign map_lin = off_map ? 17'd0
                           : 17'($unsigned(my)) * MAP_W_U + 17'($unsigned(mx));

  // Own car always sits at the view centre
  assign self_dx   = rel_x - VIEW_CX;
  assign self_dy   = row - VIEW_CY;
  assign self_hit  = in_box(self_dx, self_dy);
  assign self_addr = self_hit ? sprite_addr(me_deg, self_dx, self_dy) : 17'd0;

`ifdef SPLIT_VIEW_GHOST_EN
  // Enemy car placed relative to the camera, magnified like the map
  assign en_x    = view_r ? s0_x : s1_x;
  assign en_y    = view_r ? s0_y : s1_y;
  assign en_deg  = view_r ? s0_deg : s1_deg;
  assign en_cx   = VIEW_CX + (($signed({2'b00, en_x}) - $signed({2'b00, me_x})) <<< SCALE_SHIFT);
  assign en_cy   = VIEW_CY + (($signed({2'b00, en_y}) - $signed({2'b00, me_y})) <<< SCALE_SHIFT);
  assign en_dx   = rel_x - en_cx;
  assign en_dy   = row - en_cy;
  assign en_hit  = in_box(en_dx, en_dy);
  assign en_addr = en_hit ? sprite_addr(en_deg, en_dx, en_dy) : 17'd0;
`else
  assign car_addr_b       = 17'd0;
  assign unused_car_rgb_b = ^car_rgb_b;
`endif

  // ---- stage 1: ROM addresses and per-pixel flags ----
  // Register addresses and flags for the pixel sampled on this tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_addr   <= '0;
      car_addr_a <= '0;
      vld_p1     <= 1'b0;
      sep_p1     <= 1'b0;
      self_p1    <= 1'b0;
      off_p1     <= 1'b0;
      hs_p1      <= 1'b1;
      vs_p1      <= 1'b1;
`ifdef SPLIT_VIEW_GHOST_EN
      car_addr_b <= '0;
      en_p1      <= 1'b0;
`endif
    end else if (pix_en) begin
      map_addr   <= map_lin;
      car_addr_a <= self_addr;
      vld_p1     <= valid;
      sep_p1     <= sep;
      self_p1    <= self_hit;
      off_p1     <= off_map;
      hs_p1      <= hsync_in;
      vs_p1      <= vsync_in;
`ifdef SPLIT_VIEW_GHOST_EN
      car_addr_b <= en_addr;
      en_p1      <= en_hit;
`endif
    end
  end

  // ---- stage 2: ROM data aligned with its flags ----
  // Capture ROM outputs, which settle one clk after the address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      sep_p2   <= 1'b0;
      self_p2  <= 1'b0;
      off_p2   <= 1'b0;
      hs_p2    <= 1'b1;
      vs_p2    <= 1'b1;
      map_p2   <= '0;
      car_a_p2 <= '0;
`ifdef SPLIT_VIEW_GHOST_EN
      en_p2    <= 1'b0;
      car_b_p2 <= '0;
`endif
    end else if (pix_en) begin
      vld_p2   <= vld_p1;
      sep_p2   <= sep_p1;
      self_p2  <= self_p1;
      off_p2   <= off_p1;
      hs_p2    <= hs_p1;
      vs_p2    <= vs_p1;
      map_p2   <= map_rgb;
      car_a_p2 <= car_rgb_a;
`ifdef SPLIT_VIEW_GHOST_EN
      en_p2    <= en_p1;
      car_b_p2 <= car_rgb_b;
`endif
    end
  end

  // Layer priority: blanking, separator, own car, enemy car, off-map, map
  always_comb begin
    rgb_next = map_p2;
    if (!vld_p2)
      rgb_next = 12'h000;
    else if (sep_p2)
      rgb_next = 12'hFFF;
    else if (self_p2 && (car_a_p2 != TRANSPARENT))
      rgb_next = car_a_p2;
`ifdef SPLIT_VIEW_GHOST_EN
    else if (en_p2 && (car_b_p2 != TRANSPARENT))
      rgb_next = car_b_p2;
`endif
    else if (off_p2)
      rgb_next = OUT_BOUND_COLOR;
  end

  // ---- stage 3: registered outputs ----
  // Drive colour and the delayed syncs together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (pix_en) begin
      rgb   <= rgb_next;
      hsync <= hs_p2;
      vsync <= vs_p2;
    end
  end

endmodule

// File: tb/tb_split_view_renderer.sv
// Directed bench for split_view_renderer with default parameters.
// Map/car ROMs are modelled as registered lookups with a simple colour hash.
module tb_split_view_renderer;

  logic        clk = 1'b0;
  logic        rst, pix_en;
  logic [9:0]  h_cnt, v_cnt;
  logic        valid, hsync_in, vsync_in;
  logic [9:0]  p0_x, p0_y, p1_x, p1_y;
  logic [3:0]  p0_deg, p1_deg;
  logic [16:0] map_addr, car_addr_a, car_addr_b;
  logic [11:0] map_rgb, car_rgb_a, car_rgb_b, rgb;
  logic        hsync, vsync, frame_latched;

  int   n_vec = 0;
  int   n_err = 0;
  logic transp_a = 1'b0;
  logic transp_b = 1'b0;
  logic fl_a, fl_b;

  always #5 clk = ~clk;

  split_view_renderer dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .p0_x(p0_x), .p0_y(p0_y), .p1_x(p1_x), .p1_y(p1_y),
    .p0_deg(p0_deg), .p1_deg(p1_deg),
    .map_addr(map_addr), .map_rgb(map_rgb),
    .car_addr_a(car_addr_a), .car_addr_b(car_addr_b),
    .car_rgb_a(car_rgb_a), .car_rgb_b(car_rgb_b),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_latched(frame_latched)
  );

  function automatic logic [11:0] map_rom(input logic [16:0] a);
    return a[11:0] ^ 12'hA5A;
  endfunction
  function automatic logic [11:0] car_a_rom(input logic [16:0] a);
    return a[11:0] ^ 12'h3C3;
  endfunction
  function automatic logic [11:0] car_b_rom(input logic [16:0] a);
    return a[11:0] ^ 12'h5F5;
  endfunction

  // ROM models: data valid one clk after the address
  always @(posedge clk) begin
    map_rgb   <= map_rom(map_addr);
    car_rgb_a <= transp_a ? 12'h000 : car_a_rom(car_addr_a);
    car_rgb_b <= transp_b ? 12'h000 : car_b_rom(car_addr_b);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One pixel tick, followed by two idle clks
  task automatic pix(input logic [9:0] h, input logic [9:0] v,
                     input logic vl, input logic hs, input logic vs);
    @(negedge clk);
    h_cnt = h; v_cnt = v; valid = vl; hsync_in = hs; vsync_in = vs; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    fl_a = frame_latched;
    @(negedge clk);
    fl_b = frame_latched;
  endtask

  task automatic idle();
    pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic snap(input logic [9:0] x0, input logic [9:0] y0, input logic [3:0] d0,
                      input logic [9:0] x1, input logic [9:0] y1, input logic [3:0] d1);
    p0_x = x0; p0_y = y0; p0_deg = d0;
    p1_x = x1; p1_y = y1; p1_deg = d1;
    pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pix_en = 1'b0;
    h_cnt = '0; v_cnt = '0; valid = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    p0_x = '0; p0_y = '0; p1_x = '0; p1_y = '0; p0_deg = '0; p1_deg = '0;
    repeat (3) @(negedge clk);
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_hsync", hsync, 1'b1);
    chk("rst_vsync", vsync, 1'b1);
    chk("rst_fl", frame_latched, 1'b0);
    chk("rst_map_addr", map_addr, 17'd0);
    chk("rst_car_a", car_addr_a, 17'd0);
    chk("rst_car_b", car_addr_b, 17'd0);
    rst = 1'b0;

    // Both players at (160,120): own car centred in the left view
    snap(10'd160, 10'd120, 4'd0, 10'd160, 10'd120, 4'd0);
    pix(10'd160, 10'd240, 1'b1, 1'b1, 1'b1);
    chk("ctr_map_addr", map_addr, 17'd38560);
    chk("ctr_car_a", car_addr_a, 17'd2812);
`ifdef SPLIT_VIEW_GHOST_EN
    chk("ctr_car_b", car_addr_b, 17'd2812);
`else
    chk("ctr_car_b_tied", car_addr_b, 17'd0);
`endif
    idle();
    idle();
    chk("ctr_rgb", rgb, car_a_rom(17'd2812));
    pix(10'd123, 10'd203, 1'b1, 1'b1, 1'b1);
    chk("tl_car_a", car_addr_a, 17'd0);
    pix(10'd122, 10'd203, 1'b1, 1'b1, 1'b1);
    chk("out_car_a", car_addr_a, 17'd0);
    idle();
    chk("tl_rgb", rgb, car_a_rom(17'd0));
    idle();
    chk("out_rgb", rgb, map_rom(17'd32461));
    pix(10'd197, 10'd277, 1'b1, 1'b1, 1'b1);
    chk("br_car_a", car_addr_a, 17'd5624);

    // Player 0 near the map corner: off-map border
    transp_a = 1'b1; transp_b = 1'b1;
    snap(10'd10, 10'd10, 4'd0, 10'd10, 10'd10, 4'd0);
    pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    chk("off_map_addr", map_addr, 17'd0);
    pix(10'd300, 10'd300, 1'b1, 1'b1, 1'b1);
    chk("on_map_addr", map_addr, 17'd12880);
    idle();
    chk("off_rgb", rgb, 12'h6B4);
    idle();
    chk("on_rgb", rgb, map_rom(17'd12880));
    pix(10'd140, 10'd220, 1'b1, 1'b1, 1'b1);
    pix(10'd138, 10'd220, 1'b1, 1'b1, 1'b1);
    idle();
    chk("mx0_rgb", rgb, map_rom(17'd0));
    idle();
    chk("mxm1_rgb", rgb, 12'h6B4);
    transp_a = 1'b0; transp_b = 1'b0;

    // Separator, blanking and 2-tick sync delay
    idle();
    idle();
    pix(10'd319, 10'd10, 1'b1, 1'b0, 1'b1);
    chk("hs_not_early", hsync, 1'b1);
    pix(10'd320, 10'd10, 1'b1, 1'b1, 1'b1);
    chk("hs_not_1tick", hsync, 1'b1);
    pix(10'd319, 10'd10, 1'b0, 1'b1, 1'b0);
    chk("sep319_rgb", rgb, 12'hFFF);
    chk("hs_2tick", hsync, 1'b0);
    idle();
    chk("sep320_rgb", rgb, 12'hFFF);
    chk("hs_back", hsync, 1'b1);
    chk("vs_not_1tick", vsync, 1'b1);
    idle();
    chk("blank_rgb", rgb, 12'h000);
    chk("vs_2tick", vsync, 1'b0);

    // Mid-frame position change is ignored until the next vsync fall
    snap(10'd100, 10'd100, 4'd0, 10'd300, 10'd300, 4'd0);
    pix(10'd0, 10'd100, 1'b1, 1'b1, 1'b1);
    chk("frame_map_addr", map_addr, 17'd9620);
    chk("fl_quiet", fl_a, 1'b0);
    p0_x = 10'd200;
    pix(10'd0, 10'd100, 1'b1, 1'b1, 1'b1);
    chk("midframe_map_addr", map_addr, 17'd9620);
    pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
    chk("fl_pulse", fl_a, 1'b1);
    chk("fl_one_clk", fl_b, 1'b0);
    pix(10'd0, 10'd100, 1'b1, 1'b1, 1'b1);
    chk("newframe_map_addr", map_addr, 17'd9720);

    // Enemy ten texels to the right of player 0
    transp_a = 1'b1;
    snap(10'd100, 10'd100, 4'd1, 10'd110, 10'd100, 4'd2);
    pix(10'd180, 10'd240, 1'b1, 1'b1, 1'b1);
    chk("en_car_a", car_addr_a, 17'd8457);
`ifdef SPLIT_VIEW_GHOST_EN
    chk("en_car_b", car_addr_b, 17'd14062);
`else
    chk("en_car_b_tied", car_addr_b, 17'd0);
`endif
    idle();
    idle();
`ifdef SPLIT_VIEW_GHOST_EN
    chk("en_rgb", rgb, car_b_rom(17'd14062));
`else
    chk("noghost_rgb", rgb, map_rom(17'd32110));
`endif
    transp_a = 1'b0;
    pix(10'd180, 10'd240, 1'b1, 1'b1, 1'b1);
    pix(10'd480, 10'd240, 1'b1, 1'b1, 1'b1);
    chk("rview_car_a", car_addr_a, 17'd14062);
    chk("rview_map_addr", map_addr, 17'd32110);
    pix(10'd0, 10'd300, 1'b1, 1'b1, 1'b1);
    chk("self_wins_rgb", rgb, car_a_rom(17'd8457));

    // pix_en low: everything holds
    h_cnt = 10'd5; v_cnt = 10'd7; valid = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_rgb", rgb, car_a_rom(17'd8457));
    chk("hold_map_addr", map_addr, 17'd41620);
    chk("hold_hsync", hsync, 1'b1);

    // Asynchronous reset mid-frame
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_rgb", rgb, 12'h000);
    chk("arst_map_addr", map_addr, 17'd0);
    chk("arst_car_a", car_addr_a, 17'd0);
    @(negedge clk);
    rst = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    pix(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    chk("post_rst_t0", rgb, 12'h000);
    idle();
    chk("post_rst_t1", rgb, 12'h000);
    idle();
    chk("post_rst_t2", rgb, 12'h6B4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
